// File: rtl/mix_columns_seq_if.sv
// Valid/ready handshake bundle for the sequential MixColumns engine.
// The master drives blocks in and takes results out; the slave is the engine.
interface mix_columns_seq_if;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic         in_inv;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;
   logic         busy;

   modport master (
      output in_valid, in_data, in_inv, out_ready,
      input  in_ready, out_valid, out_data, busy
   );

   modport slave (
      input  in_valid, in_data, in_inv, out_ready,
      output in_ready, out_valid, out_data, busy
   );
endinterface

// File: rtl/mix_columns_seq.sv
// Iterative AES MixColumns / InvMixColumns engine, COLS_PER_CYCLE columns per BUSY cycle.
// A block is accepted in IDLE, transformed in place, then held in DONE until taken.
module mix_columns_seq #(
   parameter int COLS_PER_CYCLE = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   mix_columns_seq_if.slave  bus
);

   localparam int N_STEPS = 4 / COLS_PER_CYCLE;

   if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
      $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
   end

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_DONE
   } state_e;

   state_e             state_q, state_d;
   logic [3:0][31:0]   work_q, work_d;    // column c lives at index 3-c
   logic [1:0]         cnt_q, cnt_d;
   logic               inv_q, inv_d;
   logic [1:0]         col_idx;
   logic               last_step;

   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   // Only x2/x4/x8 are built per byte; every coefficient is an XOR of those and x.
   function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
      logic [7:0]  a  [4];
      logic [7:0]  x2 [4];
      logic [7:0]  x4 [4];
      logic [7:0]  x8 [4];
      logic [7:0]  b_fwd;
      logic [7:0]  b_inv;
      logic [31:0] res;
      res = '0;
      for (int r = 0; r < 4; r++) begin
         a[r]  = col[31-8*r -: 8];
         x2[r] = xtime(a[r]);
         x4[r] = xtime(x2[r]);
         x8[r] = xtime(x4[r]);
      end
      for (int r = 0; r < 4; r++) begin
         b_fwd = x2[r] ^ (x2[(r+1)%4] ^ a[(r+1)%4]) ^ a[(r+2)%4] ^ a[(r+3)%4];
         b_inv = (x8[r] ^ x4[r] ^ x2[r])
               ^ (x8[(r+1)%4] ^ x2[(r+1)%4] ^ a[(r+1)%4])
               ^ (x8[(r+2)%4] ^ x4[(r+2)%4] ^ a[(r+2)%4])
               ^ (x8[(r+3)%4] ^ a[(r+3)%4]);
         res[31-8*r -: 8] = inv ? b_inv : b_fwd;
      end
      return res;
   endfunction

   assign last_step = (cnt_q == 2'(N_STEPS - 1));

   // NOTE: reset is sampled on the clock edge only, so it sits inside the edge-triggered block.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: every comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (bus.in_valid)  state_d = ST_BUSY;
         ST_BUSY: if (last_step)     state_d = ST_DONE;
         ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
         default:                    state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready  = (state_q == ST_IDLE);
      bus.out_valid = (state_q == ST_DONE);
      bus.busy      = (state_q != ST_IDLE);
      // Partially transformed columns must never leak out.
      bus.out_data  = (state_q == ST_DONE) ? work_q : '0;
   end

   always_comb begin
      work_d  = work_q;
      cnt_d   = cnt_q;
      inv_d   = inv_q;
      col_idx = '0;
      case (state_q)
         ST_IDLE: begin
            if (bus.in_valid) begin
               work_d = bus.in_data;
               inv_d  = bus.in_inv;
               cnt_d  = '0;
            end
         end
         ST_BUSY: begin
            for (int g = 0; g < COLS_PER_CYCLE; g++) begin
               col_idx                 = 2'(int'(cnt_q) * COLS_PER_CYCLE + g);
               work_d[2'd3 - col_idx]  = mix_col(work_q[2'd3 - col_idx], inv_q);
            end
            cnt_d = last_step ? 2'd0 : cnt_q + 2'd1;
         end
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         work_q <= '0;
         cnt_q  <= '0;
         inv_q  <= 1'b0;
      end else begin
         work_q <= work_d;
         cnt_q  <= cnt_d;
         inv_q  <= inv_d;
      end
   end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Directed scoreboard bench for mix_columns_seq at COLS_PER_CYCLE = 1, 2 and 4.
// One shared stimulus is steered to the instance picked by sel.
module tb_mix_columns_seq;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [1:0]   sel = 2'd0;
   logic         in_valid = 1'b0;
   logic [127:0] in_data = '0;
   logic         in_inv = 1'b0;
   logic         out_ready = 1'b0;

   logic         in_ready_m, out_valid_m, busy_m;
   logic [127:0] out_data_m;

   int           n_tests = 0;
   int           n_fail  = 0;
   int           cyc     = 0;
   int           acc_cyc = 0;
   int           out_cyc = 0;
   logic [127:0] sb_q[$];

   mix_columns_seq_if if_c1 ();
   mix_columns_seq_if if_c2 ();
   mix_columns_seq_if if_c4 ();

   mix_columns_seq #(.COLS_PER_CYCLE(1)) u_c1 (.clk(clk), .rst_n(rst_n), .bus(if_c1));
   mix_columns_seq #(.COLS_PER_CYCLE(2)) u_c2 (.clk(clk), .rst_n(rst_n), .bus(if_c2));
   mix_columns_seq #(.COLS_PER_CYCLE(4)) u_c4 (.clk(clk), .rst_n(rst_n), .bus(if_c4));

   assign if_c1.in_valid  = in_valid  && (sel == 2'd0);
   assign if_c2.in_valid  = in_valid  && (sel == 2'd1);
   assign if_c4.in_valid  = in_valid  && (sel == 2'd2);
   assign if_c1.out_ready = out_ready && (sel == 2'd0);
   assign if_c2.out_ready = out_ready && (sel == 2'd1);
   assign if_c4.out_ready = out_ready && (sel == 2'd2);
   assign if_c1.in_data = in_data;
   assign if_c2.in_data = in_data;
   assign if_c4.in_data = in_data;
   assign if_c1.in_inv  = in_inv;
   assign if_c2.in_inv  = in_inv;
   assign if_c4.in_inv  = in_inv;

   always_comb begin
      case (sel)
         2'd1:    begin in_ready_m = if_c2.in_ready; out_valid_m = if_c2.out_valid;
                        busy_m = if_c2.busy; out_data_m = if_c2.out_data; end
         2'd2:    begin in_ready_m = if_c4.in_ready; out_valid_m = if_c4.out_valid;
                        busy_m = if_c4.busy; out_data_m = if_c4.out_data; end
         default: begin in_ready_m = if_c1.in_ready; out_valid_m = if_c1.out_valid;
                        busy_m = if_c1.busy; out_data_m = if_c1.out_data; end
      endcase
   end

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // Reference model: generic shift-and-add GF(2^8) multiply over the full matrix.
   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a, b, p;
      a = a_in; b = b_in; p = '0;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [127:0] model_mix(input logic [127:0] s, input logic inv);
      logic [7:0]   fwd_row [4];
      logic [7:0]   inv_row [4];
      logic [7:0]   acc;
      logic [127:0] res;
      fwd_row = '{8'h02, 8'h03, 8'h01, 8'h01};
      inv_row = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
      res = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            acc = '0;
            for (int k = 0; k < 4; k++)
               acc = acc ^ gmul(inv ? inv_row[k] : fwd_row[k], s[127-32*c-8*((r+k)%4) -: 8]);
            res[127-32*c-8*r -: 8] = acc;
         end
      end
      return res;
   endfunction

   function automatic int n_steps_of(input logic [1:0] s);
      return (s == 2'd0) ? 4 : (s == 2'd1) ? 2 : 1;
   endfunction

   function automatic logic [127:0] rand_block();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
      n_tests++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   task automatic timeout_fail(input string tag);
      n_tests++;
      n_fail++;
      $error("FAIL %s: timeout waiting for DUT", tag);
   endtask

   // Waits for the accept edge, pushes the expected result, returns just after that edge.
   task automatic wait_accept(input string tag, input logic [127:0] exp_v);
      int n = 0;
      @(negedge clk);
      while (!(in_valid && in_ready_m) && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) timeout_fail(tag);
      else begin
         sb_q.push_back(exp_v);
         acc_cyc = cyc;
      end
      @(posedge clk);
      #1;
   endtask

   // Returns at the negedge where out_valid is first seen.
   task automatic wait_valid(input string tag);
      int n = 0;
      @(negedge clk);
      while (!out_valid_m && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) timeout_fail(tag);
      out_cyc = cyc;
   endtask

   task automatic sb_check(input string tag);
      logic [127:0] exp_v;
      if (sb_q.size() == 0) begin
         n_tests++;
         n_fail++;
         $error("FAIL %s: scoreboard empty, observed %h", tag, out_data_m);
      end else begin
         exp_v = sb_q.pop_front();
         check(tag, out_data_m, exp_v);
      end
   endtask

   initial begin
      logic [127:0] blk;
      logic [127:0] b2b [3];
      int           prev_out;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("reset_in_ready",  128'(in_ready_m),  128'd1);
      check("reset_out_valid", 128'(out_valid_m), 128'd0);
      check("reset_busy",      128'(busy_m),      128'd0);
      check("reset_out_data",  out_data_m,        128'd0);
      @(posedge clk);
      #1;

      // Forward, one column per cycle
      sel = 2'd0; out_ready = 1'b1;
      in_data = 128'hdb135345_f20a225c_01010101_c6c6c6c6; in_inv = 1'b0; in_valid = 1'b1;
      wait_accept("c1_fwd_acc", 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6);
      in_valid = 1'b0;
      wait_valid("c1_fwd_valid");
      check("c1_fwd_latency", 128'(out_cyc - acc_cyc), 128'(n_steps_of(sel) + 1));
      sb_check("c1_fwd_data");
      @(posedge clk);
      #1;
      @(negedge clk);
      check("c1_ready_back", 128'(in_ready_m),  128'd1);
      check("c1_valid_low",  128'(out_valid_m), 128'd0);

      // Inverse and round trip, two columns per cycle
      sel = 2'd1;
      in_data = 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8; in_inv = 1'b1; in_valid = 1'b1;
      wait_accept("c2_inv_acc", 128'hdb135345_f20a225c_d4d4d4d5_2d26314c);
      in_valid = 1'b0;
      wait_valid("c2_inv_valid");
      check("c2_inv_latency", 128'(out_cyc - acc_cyc), 128'(n_steps_of(sel) + 1));
      sb_check("c2_inv_data");
      @(posedge clk);
      #1;
      in_data = 128'hdb135345_f20a225c_d4d4d4d5_2d26314c; in_inv = 1'b0; in_valid = 1'b1;
      wait_accept("c2_rt_acc", 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8);
      in_valid = 1'b0;
      wait_valid("c2_rt_valid");
      sb_check("c2_roundtrip_data");
      @(posedge clk);
      #1;

      // Backpressure, four columns per cycle
      sel = 2'd2; out_ready = 1'b0;
      blk = rand_block();
      in_data = blk; in_inv = 1'b1; in_valid = 1'b1;
      wait_accept("c4_bp_acc", model_mix(blk, 1'b1));
      in_valid = 1'b0;
      wait_valid("c4_bp_valid");
      check("c4_bp_latency", 128'(out_cyc - acc_cyc), 128'(n_steps_of(sel) + 1));
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         in_valid = ~in_valid;
         in_data  = rand_block();
         in_inv   = ~in_inv;
         @(negedge clk);
         check("c4_bp_hold_data",  out_data_m,        sb_q[0]);
         check("c4_bp_hold_valid", 128'(out_valid_m), 128'd1);
         check("c4_bp_in_ready",   128'(in_ready_m),  128'd0);
         check("c4_bp_busy",       128'(busy_m),      128'd1);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      sb_check("c4_bp_data");
      @(posedge clk);
      #1;
      @(negedge clk);
      check("c4_bp_idle_ready", 128'(in_ready_m),  128'd1);
      check("c4_bp_idle_valid", 128'(out_valid_m), 128'd0);
      check("c4_bp_idle_busy",  128'(busy_m),      128'd0);

      // Random forward block at four columns per cycle
      @(posedge clk);
      #1;
      blk = rand_block();
      in_data = blk; in_inv = 1'b0; in_valid = 1'b1;
      wait_accept("c4_fwd_acc", model_mix(blk, 1'b0));
      in_valid = 1'b0;
      wait_valid("c4_fwd_valid");
      sb_check("c4_fwd_data");
      @(posedge clk);
      #1;

      // Mode latched at accept
      sel = 2'd0;
      blk = rand_block();
      in_data = blk; in_inv = 1'b0; in_valid = 1'b1;
      wait_accept("mode_acc", model_mix(blk, 1'b0));
      in_valid = 1'b0; in_inv = 1'b1;
      wait_valid("mode_valid");
      sb_check("mode_latch_data");
      @(posedge clk);
      #1;

      // Reset in the second BUSY cycle
      in_data = rand_block(); in_inv = 1'b0; in_valid = 1'b1;
      wait_accept("rst_acc", 128'd0);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      sb_q.delete();
      @(negedge clk);
      check("midrst_out_valid", 128'(out_valid_m), 128'd0);
      check("midrst_out_data",  out_data_m,        128'd0);
      check("midrst_busy",      128'(busy_m),      128'd0);
      check("midrst_in_ready",  128'(in_ready_m),  128'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      in_data = {4{32'h2d26314c}}; in_inv = 1'b0; in_valid = 1'b1;
      wait_accept("postrst_acc", {4{32'h4d7ebdf8}});
      in_valid = 1'b0;
      wait_valid("postrst_valid");
      sb_check("postrst_data");
      @(posedge clk);
      #1;

      // Back-to-back with in_valid held high, two columns per cycle
      sel = 2'd1; out_ready = 1'b1;
      for (int i = 0; i < 3; i++) b2b[i] = rand_block();
      prev_out = 0;
      in_valid = 1'b1; in_inv = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_data = b2b[i];
         wait_accept("b2b_acc", model_mix(b2b[i], 1'b0));
         if (i < 2) in_data = b2b[i+1];
         else       in_valid = 1'b0;
         wait_valid("b2b_valid");
         if (i > 0) check("b2b_interval", 128'(out_cyc - prev_out), 128'(n_steps_of(sel) + 2));
         prev_out = out_cyc;
         sb_check("b2b_data");
         @(posedge clk);
         #1;
      end
      check("b2b_sb_empty", 128'(sb_q.size()), 128'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
